// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - decoder/memory/datapath bundle for the multi-cycle sequencer
interface multicycle_sequencer_if #(
   parameter int RETIRE_W = 32
);
   logic [6:0]          opcode;
   logic                cu_reg_write;
   logic                cu_mem_read;
   logic                cu_mem_write;
   logic                cu_branch;
   logic                cu_jump;
   logic                zero;
   logic                imem_ready;
   logic                dmem_ready;
   logic                imem_req;
   logic                ir_write;
   logic                dmem_req;
   logic                dmem_we;
   logic                rf_we;
   logic                pc_write;
   logic                pc_src;
   logic [2:0]          state;
   logic                busy;
   logic                timeout_err;
   logic [RETIRE_W-1:0] instret;

   modport slave (
      input  opcode, cu_reg_write, cu_mem_read, cu_mem_write, cu_branch, cu_jump, zero,
             imem_ready, dmem_ready,
      output imem_req, ir_write, dmem_req, dmem_we, rf_we, pc_write, pc_src,
             state, busy, timeout_err, instret
   );

   modport master (
      output opcode, cu_reg_write, cu_mem_read, cu_mem_write, cu_branch, cu_jump, zero,
             imem_ready, dmem_ready,
      input  imem_req, ir_write, dmem_req, dmem_we, rf_we, pc_write, pc_src,
             state, busy, timeout_err, instret
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - RV32I multi-cycle control sequencer with memory timeouts and instret
// SEQ_ILLEGAL_TRAP_EN: illegal opcodes enter TRAP instead of retiring as a NOP.
module multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int RETIRE_W    = 32
) (
   input logic                   clk,
   input logic                   rst,
   multicycle_sequencer_if.slave bus
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam int              WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);
   localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

   logic [2:0]          state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                err_q, err_d;
   logic [RETIRE_W-1:0] instret_q, instret_d;
   logic                retire;
   logic                legal;
   logic                wait_hit;
   logic                imem_req, ir_write, dmem_req, dmem_we, rf_we, pc_write, pc_src;

   always_comb begin
      case (bus.opcode)
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: legal = 1'b1;
         default:                                        legal = 1'b0;
      endcase
   end

   // Fault fires on the cycle the wait would reach the limit; a ready in that same cycle wins.
   assign wait_hit = TIMEOUT_EN && (wait_q == WAIT_LAST);

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      err_d    = err_q;
      retire   = 1'b0;
      imem_req = 1'b0;
      ir_write = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_write = 1'b0;
      pc_src   = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (wait_hit) begin
               err_d   = 1'b1;
               state_d = S_TRAP;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            if (legal) begin
               state_d = S_EXEC;
            end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
               state_d = S_TRAP;
`else
               pc_write = 1'b1;
               retire   = 1'b1;
               state_d  = S_FETCH;
`endif
            end
         end
         S_EXEC: begin
            if (bus.cu_branch) begin
               pc_write = 1'b1;
               pc_src   = bus.zero;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end else if (bus.cu_jump) begin
               state_d = S_WB;
            end else if (bus.cu_mem_read || bus.cu_mem_write) begin
               state_d = S_MEM;
            end else if (bus.cu_reg_write) begin
               state_d = S_WB;
            end else begin
               pc_write = 1'b1;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = bus.cu_mem_write;
            if (bus.dmem_ready) begin
               if (bus.cu_mem_write) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_hit) begin
               err_d   = 1'b1;
               state_d = S_TRAP;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WB: begin
            rf_we    = bus.cu_reg_write;
            pc_write = 1'b1;
            pc_src   = bus.cu_jump;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
      // Every state change starts a fresh wait window for the next FETCH or MEM.
      if (state_d != state_q) wait_d = '0;
      instret_d = retire ? instret_q + RETIRE_W'(1) : instret_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         err_q     <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         err_q     <= err_d;
         instret_q <= instret_d;
      end
   end

   assign bus.imem_req    = imem_req & ~rst;
   assign bus.ir_write    = ir_write & ~rst;
   assign bus.dmem_req    = dmem_req & ~rst;
   assign bus.dmem_we     = dmem_we  & ~rst;
   assign bus.rf_we       = rf_we    & ~rst;
   assign bus.pc_write    = pc_write & ~rst;
   assign bus.pc_src      = pc_src   & ~rst;
   assign bus.state       = state_q;
   assign bus.busy        = (state_q != S_TRAP);
   assign bus.timeout_err = err_q;
   assign bus.instret     = instret_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;
   localparam int TO = 4;
   localparam int RW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multicycle_sequencer_if #(.RETIRE_W(RW)) bus ();
   multicycle_sequencer #(.MEM_TIMEOUT(TO), .RETIRE_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int kind;   // 0 retire, 1 trap, 2 aborted by reset
      bit err;
      int cycles;
      int icyc;
      int irw;
      int dcyc;
      bit dwe;
      int rfwe;
      bit pcsrc;
      int iret;
   } exp_t;

   exp_t sbq[$];
   bit   irq[$];
   bit   drq[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   m_instret = 0;
   bit   m_err = 1'b0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] opc);
      logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      for (int i = 0; i < 9; i++) if (ops[i] == opc) return 1'b1;
      return 1'b0;
   endfunction

   task automatic push_cyc(input bit i, input bit d);
      irq.push_back(i);
      drq.push_back(d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      m_instret = 0;
      m_err = 1'b0;
   endtask

   // fl = {reg_write, mem_read, mem_write, branch, jump}; ab >= 0 resets after ab MEM cycles
   task automatic run_instr(input logic [6:0] opc, input logic [4:0] fl, input bit z,
                            input int di, input int dd, input int ab);
      exp_t e;
      bit rw, mr, mw, br, jp;
      {rw, mr, mw, br, jp} = fl;
      e = '{kind:0, err:m_err, cycles:0, icyc:0, irw:0, dcyc:0, dwe:0, rfwe:0, pcsrc:0,
            iret:m_instret};
      irq.delete();
      drq.delete();
      if (di >= TO) begin
         repeat (TO) push_cyc(1'b0, 1'($urandom));
         e.kind = 1; e.err = 1'b1; e.icyc = TO;
      end else begin
         repeat (di) push_cyc(1'b0, 1'($urandom));
         push_cyc(1'b1, 1'($urandom));
         e.icyc = di + 1; e.irw = 1;
         push_cyc(1'($urandom), 1'($urandom));
         if (!is_legal(opc)) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            e.kind = 1;
`else
            e.pcsrc = 1'b0;
`endif
         end else begin
            push_cyc(1'($urandom), 1'($urandom));
            if (br) begin
               e.pcsrc = z;
            end else if (jp) begin
               push_cyc(1'($urandom), 1'($urandom));
               e.rfwe = int'(rw); e.pcsrc = 1'b1;
            end else if (mr || mw) begin
               if (ab >= 0) begin
                  repeat (ab) push_cyc(1'($urandom), 1'b0);
                  e.kind = 2; e.dcyc = ab; e.dwe = mw && (ab > 0);
               end else if (dd >= TO) begin
                  repeat (TO) push_cyc(1'($urandom), 1'b0);
                  e.kind = 1; e.err = 1'b1; e.dcyc = TO; e.dwe = mw;
               end else begin
                  repeat (dd) push_cyc(1'($urandom), 1'b0);
                  push_cyc(1'($urandom), 1'b1);
                  e.dcyc = dd + 1; e.dwe = mw;
                  if (!mw) begin
                     push_cyc(1'($urandom), 1'($urandom));
                     e.rfwe = int'(rw);
                  end
               end
            end else if (rw) begin
               push_cyc(1'($urandom), 1'($urandom));
               e.rfwe = 1;
            end
         end
      end
      e.cycles = irq.size();
      sbq.push_back(e);
      if (e.kind == 0) m_instret++;
      if (e.err) m_err = 1'b1;

      bus.opcode = opc;
      {bus.cu_reg_write, bus.cu_mem_read, bus.cu_mem_write, bus.cu_branch, bus.cu_jump} = fl;
      bus.zero = z;
      for (int i = 0; i < irq.size(); i++) begin
         bus.imem_ready = irq[i];
         bus.dmem_ready = drq[i];
         @(posedge clk); #1;
      end
      if (e.kind == 1) begin
         repeat (3) begin
            bus.imem_ready = 1'($urandom);
            bus.dmem_ready = 1'($urandom);
            @(posedge clk); #1;
         end
      end
      if (e.kind != 0) do_reset();
   endtask

   task automatic run_random();
      logic [6:0] opc;
      logic [4:0] fl;
      int         di, dd, ab;
      if ($urandom_range(0, 7) == 0) begin
         opc = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'($urandom);
         while (is_legal(opc)) opc = 7'($urandom);
      end else begin
         opc = 7'b0110011;
         case ($urandom_range(0, 8))
            0: opc = 7'b0110011; 1: opc = 7'b0010011; 2: opc = 7'b0000011;
            3: opc = 7'b0100011; 4: opc = 7'b1100011; 5: opc = 7'b1101111;
            6: opc = 7'b1100111; 7: opc = 7'b0110111; default: opc = 7'b0010111;
         endcase
      end
      case (opc)
         7'b0000011:             fl = 5'b11000;
         7'b0100011:             fl = 5'b00100;
         7'b1100011:             fl = 5'b00010;
         7'b1101111, 7'b1100111: fl = 5'b10001;
         default:                fl = 5'b10000;
      endcase
      if ($urandom_range(0, 3) == 0) fl = 5'($urandom);
      di = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO - 1);
      dd = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO - 1) : -1;
      run_instr(opc, fl, 1'($urandom), di, dd, ab);
   endtask

   int cyc = 0, icyc = 0, irw = 0, dcyc = 0, rfwe = 0;
   bit dwe = 1'b0, prev_rst = 1'b0, in_trap = 1'b0;
   int trap_iret = 0;

   task automatic pop_cmp(input int kind_obs);
      exp_t e;
      if (sbq.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind_obs, $time);
         return;
      end
      e = sbq.pop_front();
      check("event_kind", kind_obs, e.kind);
      check("cycles", cyc, e.cycles);
      check("imem_req_cycles", icyc, e.icyc);
      check("ir_write_count", irw, e.irw);
      check("dmem_req_cycles", dcyc, e.dcyc);
      check("dmem_we", dwe, e.dwe);
      check("rf_we_count", rfwe, e.rfwe);
      check("pc_src", bus.pc_src, e.pcsrc);
      check("instret", bus.instret, e.iret);
      check("timeout_err", bus.timeout_err, e.err);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         check("strobes_in_rst", {bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_we,
                                  bus.rf_we, bus.pc_write, bus.pc_src}, 0);
         if (prev_rst) begin
            check("rst_state", bus.state, 0);
            check("rst_instret", bus.instret, 0);
            check("rst_timeout_err", bus.timeout_err, 0);
         end else if (sbq.size() > 0 && sbq[0].kind == 2) begin
            pop_cmp(2);
         end
         cyc = 0; icyc = 0; irw = 0; dcyc = 0; rfwe = 0; dwe = 1'b0; in_trap = 1'b0;
      end else if (bus.state == 3'd5) begin
         if (!in_trap) begin
            pop_cmp(1);
            in_trap = 1'b1;
            trap_iret = int'(bus.instret);
         end
         check("trap_busy", bus.busy, 0);
         check("trap_strobes", {bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_we,
                                bus.rf_we, bus.pc_write, bus.pc_src}, 0);
         check("trap_instret", bus.instret, trap_iret);
      end else begin
         cyc++;
         icyc += int'(bus.imem_req);
         irw  += int'(bus.ir_write);
         dcyc += int'(bus.dmem_req);
         rfwe += int'(bus.rf_we);
         if (bus.dmem_req) dwe = dwe | bus.dmem_we;
         if (bus.pc_write) begin
            check("busy", bus.busy, 1);
            pop_cmp(0);
            cyc = 0; icyc = 0; irw = 0; dcyc = 0; rfwe = 0; dwe = 1'b0;
         end
         if (cyc > 64) begin
            check("instr_cycle_bound", cyc, 64);
            cyc = 0;
         end
      end
      prev_rst = rst;
   end

   initial begin
      rst = 1'b1;
      bus.opcode = '0;
      bus.cu_reg_write = 1'b0; bus.cu_mem_read = 1'b0; bus.cu_mem_write = 1'b0;
      bus.cu_branch = 1'b0; bus.cu_jump = 1'b0; bus.zero = 1'b0;
      bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      run_instr(7'b0110011, 5'b10000, 1'b0, 1, 0, -1);       // R-type, ready on 2nd FETCH cycle
      run_instr(7'b0000011, 5'b11000, 1'b0, 0, 2, -1);       // load, 3 dmem_req cycles
      run_instr(7'b0100011, 5'b00100, 1'b0, 0, 2, -1);       // store
      run_instr(7'b1100011, 5'b00010, 1'b1, 0, 0, -1);       // branch taken
      run_instr(7'b1100011, 5'b00010, 1'b0, 2, 0, -1);       // branch not taken
      run_instr(7'b1101111, 5'b10001, 1'b0, 0, 0, -1);       // jal
      run_instr(7'b0000000, 5'b00000, 1'b0, 0, 0, -1);       // illegal opcode
      run_instr(7'b0110011, 5'b10000, 1'b0, TO - 1, 0, -1);  // ready on the limit cycle
      run_instr(7'b0000011, 5'b11000, 1'b0, 0, TO - 1, -1);
      run_instr(7'b0110011, 5'b10000, 1'b0, TO, 0, -1);      // fetch timeout
      run_instr(7'b0100011, 5'b00100, 1'b0, 0, TO, -1);      // mem timeout
      run_instr(7'b0000011, 5'b11000, 1'b0, 0, TO, 2);       // reset during MEM
      run_instr(7'b0010011, 5'b10000, 1'b0, 0, 0, -1);
      repeat (400) run_random();
      repeat (3) begin @(posedge clk); #1; end
      check("scoreboard_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
